// File: rtl/inst_mem_loader.sv
// Instruction memory loader: receives a framed, checksummed program image as a
// byte stream, writes little-endian words to consecutive addresses, and releases core_rst.
module inst_mem_loader #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    // Largest legal word count: exactly fills the memory.
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

    state_t           state, state_next;
    logic [7:0]       len_lo;
    logic [15:0]      len;
    logic [15:0]      word_cnt;
    logic [1:0]       byte_idx;
    logic [7:0]       csum;
    logic [WIDTH-1:0] word_buf;
    logic [WIDTH-1:0] word_next;
    logic [16:0]      len_in;
    logic             accept;
    logic             load_start;
    logic             last_word;

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        core_rst   = 1'b1;
        load_start = 1'b0;
        len_in     = {1'b0, byte_data, len_lo};
        last_word  = (byte_idx == 2'd3) && ((word_cnt + 16'd1) == len);
        word_next  = word_buf;
        word_next[{byte_idx, 3'b000} +: 8] = byte_data;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LEN_LO;
                    load_start = 1'b1;
                end
            end
            S_LEN_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    if (len_in > DEPTH)     state_next = S_ERR;
                    else if (len_in == '0)  state_next = S_CHECK;
                    else                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && last_word) state_next = S_CHECK;
            end
            S_CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) state_next = (byte_data == csum) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                done     = 1'b1;
                core_rst = 1'b0;
                if (start) begin
                    state_next = S_LEN_LO;
                    load_start = 1'b1;
                end
            end
            S_ERR: begin
                err = 1'b1;
                if (start) begin
                    state_next = S_LEN_LO;
                    load_start = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        accept = byte_valid && byte_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            len_lo    <= '0;
            len       <= '0;
            word_cnt  <= '0;
            byte_idx  <= '0;
            csum      <= '0;
            word_buf  <= '0;
        end else begin
            state  <= state_next;
            mem_we <= 1'b0;

            if (load_start) begin
                csum     <= '0;
                word_cnt <= '0;
                byte_idx <= '0;
                word_buf <= '0;
            end

            if (accept) begin
                unique case (state)
                    S_LEN_LO: begin
                        len_lo <= byte_data;
                        csum   <= csum ^ byte_data;
                    end
                    S_LEN_HI: begin
                        len  <= {byte_data, len_lo};
                        csum <= csum ^ byte_data;
                    end
                    S_DATA: begin
                        csum     <= csum ^ byte_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            // Word complete: issue the write next cycle at the current count.
                            mem_we    <= 1'b1;
                            mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
                            mem_wdata <= word_next;
                            word_cnt  <= word_cnt + 16'd1;
                            word_buf  <= '0;
                        end else begin
                            word_buf <= word_next;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: directed frames plus random frames
// checked against a frame-level reference model of the expected writes and outcome.
module tb_inst_mem_loader;

    localparam int AW = 11;

    typedef logic [7:0] byte_q_t[$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    logic          both_seen = 1'b0;
    logic          rb_diff   = 1'b0;

    inst_mem_loader #(.WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
        end
        if (done === 1'b1 && err === 1'b1) both_seen = 1'b1;
        if (byte_ready !== busy) rb_diff = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned t;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (byte_ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) check("ready_timeout", {63'd0, byte_ready}, 64'd1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_we"},     {63'd0, mem_we},     64'd0);
        check({tag, "_mem_addr"},   {53'd0, mem_addr},   64'd0);
        check({tag, "_mem_wdata"},  {32'd0, mem_wdata},  64'd0);
        check({tag, "_byte_ready"}, {63'd0, byte_ready}, 64'd0);
        check({tag, "_busy"},       {63'd0, busy},       64'd0);
        check({tag, "_done"},       {63'd0, done},       64'd0);
        check({tag, "_err"},        {63'd0, err},        64'd0);
        check({tag, "_core_rst"},   {63'd0, core_rst},   64'd1);
    endtask

    // Reference model works on the whole frame: length, payload words, XOR rule.
    task automatic run_frame(input byte_q_t fr, input int unsigned maxgap, input int inj,
                             input string tag);
        int unsigned n;
        int unsigned nsend;
        int unsigned nw;
        bit          ovf;
        bit          exp_done;
        logic [7:0]  x;
        logic [31:0] w;

        n   = int'(fr[0]) + 256 * int'(fr[1]);
        ovf = (n > (1 << AW));
        nsend = ovf ? 2 : 3 + 4 * n;
        nw    = ovf ? 0 : n;
        x = 8'h00;
        exp_done = 1'b0;
        if (!ovf) begin
            for (int i = 0; i < 2 + 4 * int'(n); i++) x = x ^ fr[i];
            exp_done = (fr[2 + 4 * n] == x);
        end

        got_addr.delete();
        got_data.delete();
        pulse_start();
        check({tag, "_busy_after_start"}, {63'd0, busy}, 64'd1);
        check({tag, "_done_clr"}, {62'd0, done, err}, 64'd0);

        for (int i = 0; i < int'(nsend); i++) begin
            if (i == inj) begin
                pulse_start();
                check({tag, "_start_ignored"}, {63'd0, busy}, 64'd1);
            end
            send_byte(fr[i], $urandom_range(maxgap, 0));
            if (!ovf && n > 0 && i == 1 + 4 * int'(n)) begin
                check({tag, "_last_we"},   {63'd0, mem_we},   64'd1);
                check({tag, "_last_addr"}, {53'd0, mem_addr}, 64'(n - 1));
            end
        end

        check({tag, "_done"},       {63'd0, done},       64'(exp_done));
        check({tag, "_err"},        {63'd0, err},        64'(!exp_done));
        check({tag, "_core_rst"},   {63'd0, core_rst},   64'(!exp_done));
        check({tag, "_busy_end"},   {63'd0, busy},       64'd0);
        check({tag, "_ready_end"},  {63'd0, byte_ready}, 64'd0);
        tick();
        check({tag, "_nwrites"}, 64'(got_addr.size()), 64'(nw));
        for (int i = 0; i < int'(nw) && i < got_addr.size(); i++) begin
            w = 32'(fr[2 + 4*i]) | (32'(fr[3 + 4*i]) << 8) |
                (32'(fr[4 + 4*i]) << 16) | (32'(fr[5 + 4*i]) << 24);
            check($sformatf("%s_addr%0d", tag, i), {53'd0, got_addr[i]}, 64'(i % (1 << AW)));
            check($sformatf("%s_data%0d", tag, i), {32'd0, got_data[i]}, {32'd0, w});
        end
    endtask

    initial begin
        byte_q_t s1;
        byte_q_t fr;
        int unsigned n;
        logic [7:0] x;

        s1 = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h22};

        rst = 1'b1;
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        run_frame(s1, 0, -1, "s1");

        fr = s1;
        fr[10] = 8'h23;
        run_frame(fr, 0, -1, "s2_badchk");
        run_frame(s1, 0, -1, "s2_recover");

        fr = {8'h00, 8'h00, 8'h00};
        run_frame(fr, 0, -1, "s3_empty");

        fr = {8'h01, 8'h08};
        run_frame(fr, 0, -1, "s4_ovf");

        run_frame(s1, 2, 6, "s5_gaps");

        // Abort mid-load with the first word's write already issued.
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(s1[i], 0);
        rst = 1'b1;
        tick();
        check_reset_values("s6_rst");
        rst = 1'b0;
        tick();
        check("s6_idle_no_we", {63'd0, mem_we}, 64'd0);
        run_frame(s1, 0, -1, "s6_reload");

        // Full-depth image: last write at the top address.
        n = 1 << AW;
        fr = {8'(n), 8'(n >> 8)};
        x = fr[0] ^ fr[1];
        for (int i = 0; i < 4 * int'(n); i++) begin
            fr.push_back(8'($urandom));
            x = x ^ fr[fr.size() - 1];
        end
        fr.push_back(x);
        run_frame(fr, 0, -1, "full");

        fr = {8'h01, 8'h08};
        fr[0] = 8'h01;
        run_frame({8'h01, 8'h08}, 1, -1, "ovf_by_one");

        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(9, 0) == 0) n = $urandom_range(65535, 2049);
            else n = $urandom_range(5, 0);
            fr = {8'(n), 8'(n >> 8)};
            x = fr[0] ^ fr[1];
            if (n <= (1 << AW)) begin
                for (int i = 0; i < 4 * int'(n); i++) begin
                    fr.push_back(8'($urandom));
                    x = x ^ fr[fr.size() - 1];
                end
                if ($urandom_range(3, 0) == 0) x = x ^ 8'(1 << $urandom_range(7, 0));
                fr.push_back(x);
            end
            run_frame(fr, 2, -1, $sformatf("rnd%0d", it));
        end

        check("done_err_exclusive", {63'd0, both_seen}, 64'd0);
        check("ready_tracks_busy",  {63'd0, rb_diff},   64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer side of the instruction memory. The core's fetch stage only reads instruction memory; this block fills it.
- Receives a framed program image as a byte stream over a valid/ready handshake, for example from a UART receiver or a testbench.
- Assembles little-endian 32-bit instruction words and writes them to consecutive word addresses.
- Holds the processor core in reset until a complete image with a valid checksum has been written.

Parameters:
- WIDTH, 32: instruction word width in bits. Fixed at 4 bytes per word.
- ADDR_WIDTH, 11: word-address width of instruction memory. Depth is 2^ADDR_WIDTH = 2048 words.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle pulse that begins a load.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  incoming stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write enable, one-cycle pulse.
- mem_addr  output  ADDR_WIDTH  word address of the write.
- mem_wdata  output  WIDTH  instruction word to write.
- core_rst  output  1  reset to the pipeline core. High except in DONE.
- busy  output  1  a load is in progress.
- done  output  1  image loaded and checksum good.
- err  output  1  load aborted (length overflow or checksum mismatch).

Behaviour:
- Reset is synchronous, active-high, applied on the clk edge. Reset values:
  - state IDLE
  - mem_we 0, mem_addr 0, mem_wdata 0
  - byte_ready 0, busy 0, done 0, err 0
  - core_rst 1
  - internal count, checksum and byte index all 0
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N payload bytes, then one CHK byte.
- Checksum rule: CHK must equal the XOR of every byte from LEN_LO through the last payload byte.
- Handshake: a byte transfers on a rising edge where byte_valid && byte_ready. byte_data is ignored otherwise. Stalls of any length on byte_valid are legal.
- byte_ready is high exactly in states LEN_LO, LEN_HI, DATA and CHECK.
- busy is high in the same four states.
- States and transitions:
  - IDLE: start -> LEN_LO. Clears the checksum, address counter and byte index.
  - LEN_LO: on accept, latch N[7:0] -> LEN_HI.
  - LEN_HI: on accept, latch N[15:8], then:
    - N > 2^ADDR_WIDTH -> ERR, with no memory write.
    - N == 0 -> CHECK.
    - otherwise -> DATA.
  - DATA: on accept, the byte at index k (0..3) goes into word bits [8k+7:8k].
    - On the 4th byte, the word is registered. mem_we pulses high for exactly the next cycle, with mem_addr = current word count and mem_wdata = the assembled word. The address then increments.
    - byte_ready stays high during the write pulse, so back-to-back bytes are accepted.
    - After the 4th byte of word N -> CHECK.
  - CHECK: on accept:
    - byte == running XOR -> DONE.
    - otherwise -> ERR.
  - DONE: done=1, core_rst=0. start -> LEN_LO; done and core_rst return to their load values on that same edge.
  - ERR: err=1, core_rst=1. start -> LEN_LO; err clears.
- start is ignored in LEN_LO, LEN_HI, DATA and CHECK.
- done and err are never high together. Both are 0 while busy.
- Latency:
  - Final mem_we occurs 1 cycle after the last payload byte is accepted.
  - done or err is set 1 cycle after the CHK byte is accepted, or after the LEN_HI byte on overflow.
- Boundaries:
  - N = 2^ADDR_WIDTH is legal. The last write goes to address 2^ADDR_WIDTH-1 and the address never wraps.
  - Writes already issued before an ERR are not undone.
  - rst mid-load discards the partial word and any pending write. No mem_we is issued in the cycle after rst.
- mem_addr and mem_wdata are don't-care when mem_we=0, but must hold their last values (no glitching to X).

Test Plan:
1. rst, then start, then stream 02 00 13 00 00 00 93 00 A0 00 22 with no gaps:
   - mem_we pulses at addr 0 with 0x00000013, then at addr 1 with 0x00A00093.
   - done=1, core_rst=0, err=0.
2. Same stream with CHK=0x23:
   - both writes still occur.
   - err=1, done=0, core_rst=1.
   - start followed by a correct stream then reaches done=1.
3. Stream 00 00 00 (N=0):
   - no mem_we.
   - done=1 one cycle after the third byte is accepted.
4. Stream 01 08 (N=0x0801):
   - err=1 one cycle after the LEN_HI byte.
   - byte_ready=0, no mem_we, core_rst=1.
5. Scenario 1 with byte_valid high only every third cycle, plus a start pulse injected mid-DATA:
   - identical writes and done=1.
   - the start pulse has no effect.
6. rst asserted after the 6th byte of scenario 1:
   - next cycle is IDLE with all reset values and no mem_we.
   - a fresh start and full stream writes addr 0 first, then reaches done.
